// File: rtl/telemetry_rcv.sv
// telemetry_rcv: e-bike telemetry frame decoder.
// Hunts AA 55 sync, assembles three 12b fields, flags errors.
module telemetry_rcv #(
  parameter int TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rdy,
  output logic [11:0] batt_v,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frm_err,
  output logic        tmo,
  output logic [7:0]  err_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    SYNC1 = 2'd0,
    SYNC2 = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      idx_q;
  logic [TW-1:0]   cnt_q;
  logic [5:0][7:0] shadow_q;
  logic            chk_q;

  logic accept;
  logic expire;
  logic tmo_hit;
  logic last_byte;
  logic pad_ok;
  logic vld_d;
  logic ferr_d;

  // rx_rdy is ignored during the ack cycle so a byte is taken once
  assign accept    = rx_rdy & ~clr_rdy;
  assign expire    = (cnt_q == TLAST);
  assign last_byte = (idx_q == 3'd5);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SYNC1;
    else        state_q <= state_d;
  end

  // next-state: sync hunt, payload count, idle timeout
  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      SYNC1: begin
        if (accept && rx_data == 8'hAA)
          state_d = SYNC2;
      end
      SYNC2: begin
        if (accept) begin
          if (rx_data == 8'h55)      state_d = DATA;
          else if (rx_data == 8'hAA) state_d = SYNC2;
          else                       state_d = SYNC1;
        end else if (expire) begin
          tmo_hit = 1'b1;
          state_d = SYNC1;
        end
      end
      DATA: begin
        if (accept) begin
          if (last_byte) state_d = SYNC1;
        end else if (expire) begin
          tmo_hit = 1'b1;
          state_d = SYNC1;
        end
      end
      default: state_d = SYNC1;
    endcase
  end

  // output decode: pad nibbles of bytes 0,2,4 must be zero
  always_comb begin
    pad_ok = (shadow_q[0][7:4] == 4'h0) &&
             (shadow_q[2][7:4] == 4'h0) &&
             (shadow_q[4][7:4] == 4'h0);
    vld_d  = chk_q & pad_ok;
    ferr_d = chk_q & ~pad_ok;
  end

  // byte index, shadow capture and frame-check strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 3'd0;
      shadow_q <= '0;
      chk_q    <= 1'b0;
    end else begin
      chk_q <= (state_q == DATA) & accept & last_byte;
      if (state_q == DATA && accept)
        shadow_q[idx_q] <= rx_data;
      if (state_d != DATA)
        idx_q <= 3'd0;
      else if (state_q == DATA && accept)
        idx_q <= idx_q + 3'd1;
    end
  end

  // idle counter: runs only between bytes of a frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (accept || state_q == SYNC1 || tmo_hit)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

  // registered outputs and saturating error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_rdy <= 1'b0;
      batt_v  <= '0;
      curr    <= '0;
      torque  <= '0;
      vld     <= 1'b0;
      frm_err <= 1'b0;
      tmo     <= 1'b0;
      err_cnt <= '0;
    end else begin
      clr_rdy <= accept;
      vld     <= vld_d;
      frm_err <= ferr_d;
      tmo     <= tmo_hit;
      if (vld_d) begin
        batt_v <= {shadow_q[0][3:0], shadow_q[1]};
        curr   <= {shadow_q[2][3:0], shadow_q[3]};
        torque <= {shadow_q[4][3:0], shadow_q[5]};
      end
      if ((ferr_d || tmo_hit) && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_telemetry_rcv.sv
// tb_telemetry_rcv: scoreboard bench for telemetry_rcv.
// Expected frames queued on send, popped on vld.
module tb_telemetry_rcv;

  localparam int TMO = 256;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rdy;
  logic [11:0] batt_v;
  logic [11:0] curr;
  logic [11:0] torque;
  logic        vld;
  logic        frm_err;
  logic        tmo;
  logic [7:0]  err_cnt;

  telemetry_rcv #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .clr_rdy (clr_rdy),
    .batt_v  (batt_v),
    .curr    (curr),
    .torque  (torque),
    .vld     (vld),
    .frm_err (frm_err),
    .tmo     (tmo),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int vld_n = 0;
  int ferr_n = 0;
  int tmo_n = 0;
  int clr_n = 0;
  int long_n = 0;
  int err_exp = 0;

  logic [35:0] exp_q[$];
  logic [35:0] obs_q[$];
  logic pv, pf, pt, pc;

  // monitor: capture frames and count pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (vld) begin
        obs_q.push_back({batt_v, curr, torque});
        vld_n++;
      end
      if (frm_err) ferr_n++;
      if (tmo) tmo_n++;
      if (clr_rdy) clr_n++;
      if ((vld && pv) || (frm_err && pf) || (tmo && pt) ||
          (clr_rdy && pc) || (frm_err && tmo))
        long_n++;
    end
    pv = vld; pf = frm_err; pt = tmo; pc = clr_rdy;
  end

  task automatic bump_err();
    if (err_exp < 255) err_exp++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    rx_data = b;
    rx_rdy  = 1'b1;
    n = 0;
    while (!clr_rdy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!clr_rdy) begin
      failures++;
      $display("FAIL ack_wait: clr_rdy=%b required 1", clr_rdy);
    end
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] a, input logic [11:0] c,
                            input logic [11:0] t, input logic [3:0] pad);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte({pad, a[11:8]});
    send_byte(a[7:0]);
    send_byte({4'h0, c[11:8]});
    send_byte(c[7:0]);
    send_byte({4'h0, t[11:8]});
    send_byte(t[7:0]);
    if (pad == 4'h0) exp_q.push_back({a, c, t});
    else bump_err();
  endtask

  task automatic wait_frame(input string name);
    int n;
    logic [35:0] e, o;
    n = 0;
    while (obs_q.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_vld: obs=%0d exp=%0d frames, required 1 each",
               name, obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        failures++;
        $display("FAIL %s_data: got %h required %h", name, o, e);
      end
    end
  endtask

  task automatic check_err(input string name);
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'(err_exp)) begin
      failures++;
      $display("FAIL %s_err_cnt: got %0d required %0d", name, err_cnt, err_exp);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({batt_v, curr, torque, vld, frm_err, tmo, err_cnt, clr_rdy} !== '0) begin
      failures++;
      $display("FAIL %s: b=%h c=%h t=%h v=%b f=%b to=%b e=%h cr=%b required all 0",
               name, batt_v, curr, torque, vld, frm_err, tmo, err_cnt, clr_rdy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("after_release");
  endtask

  task automatic test_basic();
    int v0;
    v0 = vld_n;
    send_frame(12'hABC, 12'h123, 12'hFFF, 4'h0);
    wait_frame("basic");
    repeat (5) @(negedge clk);
    checks++;
    if (vld_n - v0 != 1) begin
      failures++;
      $display("FAIL basic_vld_count: got %0d required 1", vld_n - v0);
    end
    check_err("basic");
  endtask

  task automatic test_latency();
    int n;
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h02);
    send_byte(8'h22);
    send_byte(8'h03);
    @(posedge clk); #1;
    rx_data = 8'h33;
    rx_rdy  = 1'b1;
    exp_q.push_back({12'h111, 12'h222, 12'h333});
    n = 0;
    while (!vld && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL latency: got %0d cycles required 2", n);
    end
    rx_rdy = 1'b0;
    wait_frame("latency");
  endtask

  task automatic test_junk_sync();
    send_byte(8'h12);
    send_byte(8'hAA);
    send_frame(12'h001, 12'h002, 12'h003, 4'h0);
    wait_frame("junk_sync");
  endtask

  task automatic test_payload_aa();
    send_frame(12'hAAA, 12'h5AA, 12'hCAA, 4'h0);
    wait_frame("payload_aa");
    send_frame(12'h001, 12'h002, 12'h003, 4'h0);
    wait_frame("restore");
  endtask

  task automatic test_frame_err();
    int f0, v0;
    f0 = ferr_n;
    v0 = vld_n;
    send_frame(12'hABC, 12'h123, 12'hFFF, 4'h1);
    repeat (6) @(negedge clk);
    checks++;
    if (ferr_n - f0 != 1 || vld_n != v0) begin
      failures++;
      $display("FAIL frame_err_pulse: ferr=%0d vld=%0d required 1 and 0",
               ferr_n - f0, vld_n - v0);
    end
    checks++;
    if ({batt_v, curr, torque} !== {12'h001, 12'h002, 12'h003}) begin
      failures++;
      $display("FAIL frame_err_hold: got %h %h %h required 001 002 003",
               batt_v, curr, torque);
    end
    check_err("frame_err");
  endtask

  task automatic test_timeout();
    int n, t0;
    t0 = tmo_n;
    checks++;
    if (tmo_n != 0) begin
      failures++;
      $display("FAIL tmo_idle_sync1: got %0d tmo required 0", tmo_n);
    end
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h0A);
    n = 0;
    while (tmo_n == t0 && n < TMO + 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tmo_n != t0 + 1 || n < TMO - 10 || n > TMO + 5) begin
      failures++;
      $display("FAIL timeout: tmo=%0d after %0d cycles required 1 near %0d",
               tmo_n - t0, n, TMO);
    end
    bump_err();
    check_err("timeout");
    send_frame(12'h456, 12'h789, 12'h0DE, 4'h0);
    wait_frame("after_tmo");
  endtask

  task automatic test_back_to_back();
    int c0, f0, v0;
    c0 = clr_n;
    f0 = ferr_n;
    v0 = vld_n;
    for (int i = 0; i < 300; i++)
      send_frame(12'(i), 12'h000, 12'h000, 4'h3);
    repeat (6) @(negedge clk);
    checks++;
    if (clr_n - c0 != 2400) begin
      failures++;
      $display("FAIL clr_rdy_count: got %0d required 2400", clr_n - c0);
    end
    checks++;
    if (ferr_n - f0 != 300 || vld_n != v0) begin
      failures++;
      $display("FAIL b2b_errs: ferr=%0d vld=%0d required 300 and 0",
               ferr_n - f0, vld_n - v0);
    end
    check_err("saturate");
    checks++;
    if (long_n != 0) begin
      failures++;
      $display("FAIL pulse_width: got %0d bad pulses required 0", long_n);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h0A);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("reset_mid");
    exp_q.delete();
    obs_q.delete();
    err_exp = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_byte(8'h00);
    send_byte(8'h05);
    send_frame(12'h005, 12'h006, 12'h007, 4'h0);
    wait_frame("resync");
    check_err("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_junk_sync();
    test_payload_aa();
    test_frame_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
